// File: rtl/hmmm_loader.sv
// Program loader for the hmmm core: turns a byte stream into big-endian words
// written through the core's pgrm_addr/pgrm_data port, wrapped in core reset pulses.
module hmmm_loader #(
   parameter int                ADDR_W    = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        pgrm_addr,
   output logic        pgrm_data,
   output logic [15:0] io_out,
   output logic        io_oe,
   output logic        cpu_rst,
   output logic        busy,
   output logic        done
);

   // state    | meaning
   // IDLE     | waiting for start
   // PRE_RST  | reset pulse to core before loading
   // GET_CNT  | take word-count byte (0 means 256)
   // GET_HI   | take instruction high byte
   // GET_LO   | take instruction low byte
   // WR_ADDR  | address phase on core io bus
   // WR_DATA  | data phase on core io bus
   // POST_RST | reset pulse to core after loading
   // DONE     | completion pulse
   typedef enum logic [3:0] {
      IDLE, PRE_RST, GET_CNT, GET_HI, GET_LO, WR_ADDR, WR_DATA, POST_RST, DONE
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0]       word_q, word_d;
   logic [8:0]        cnt_q, cnt_d;
   logic [8:0]        wcnt_q, wcnt_d;

   logic        in_ready_q, in_ready_d;
   logic        pgrm_addr_q, pgrm_addr_d;
   logic        pgrm_data_q, pgrm_data_d;
   logic [15:0] io_out_q, io_out_d;
   logic        io_oe_q, io_oe_d;
   logic        cpu_rst_q, cpu_rst_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   logic accept;

   assign accept = in_valid && in_ready_q;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      word_d  = word_q;
      cnt_d   = cnt_q;
      wcnt_d  = wcnt_q;
      case (state_q)
         IDLE: begin
            if (start) state_d = PRE_RST;
         end
         PRE_RST: begin
            addr_d  = BASE_ADDR;
            wcnt_d  = '0;
            state_d = GET_CNT;
         end
         GET_CNT: begin
            if (accept) begin
               cnt_d   = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
               state_d = GET_HI;
            end
         end
         GET_HI: begin
            if (accept) begin
               word_d[15:8] = in_data;
               state_d      = GET_LO;
            end
         end
         GET_LO: begin
            if (accept) begin
               word_d[7:0] = in_data;
               state_d     = WR_ADDR;
            end
         end
         WR_ADDR: begin
            state_d = WR_DATA;
         end
         WR_DATA: begin
            addr_d  = addr_q + ADDR_W'(1);
            wcnt_d  = wcnt_q + 9'd1;
            state_d = (wcnt_d == cnt_q) ? POST_RST : GET_HI;
         end
         POST_RST: begin
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state so every port comes straight off a flop.
   always_comb begin
      in_ready_d  = 1'b0;
      pgrm_addr_d = 1'b0;
      pgrm_data_d = 1'b0;
      io_out_d    = '0;
      io_oe_d     = 1'b0;
      cpu_rst_d   = 1'b0;
      done_d      = 1'b0;
      busy_d      = (state_d != IDLE);
      case (state_d)
         PRE_RST, POST_RST: cpu_rst_d = 1'b1;
         GET_CNT, GET_HI, GET_LO: in_ready_d = 1'b1;
         WR_ADDR: begin
            pgrm_addr_d = 1'b1;
            io_oe_d     = 1'b1;
            io_out_d    = 16'(addr_d);
         end
         WR_DATA: begin
            pgrm_data_d = 1'b1;
            io_oe_d     = 1'b1;
            io_out_d    = word_d;
         end
         DONE: done_d = 1'b1;
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         addr_q      <= BASE_ADDR;
         word_q      <= '0;
         cnt_q       <= '0;
         wcnt_q      <= '0;
         in_ready_q  <= 1'b0;
         pgrm_addr_q <= 1'b0;
         pgrm_data_q <= 1'b0;
         io_out_q    <= '0;
         io_oe_q     <= 1'b0;
         cpu_rst_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         word_q      <= word_d;
         cnt_q       <= cnt_d;
         wcnt_q      <= wcnt_d;
         in_ready_q  <= in_ready_d;
         pgrm_addr_q <= pgrm_addr_d;
         pgrm_data_q <= pgrm_data_d;
         io_out_q    <= io_out_d;
         io_oe_q     <= io_oe_d;
         cpu_rst_q   <= cpu_rst_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign pgrm_addr = pgrm_addr_q;
   assign pgrm_data = pgrm_data_q;
   assign io_out    = io_out_q;
   assign io_oe     = io_oe_q;
   assign cpu_rst   = cpu_rst_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
